// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: sigma constants, round count, state types and
// word helpers used by the LED demo datapath.
package chacha20_pkg;

  localparam int ROUNDS = 20;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef logic [15:0][31:0] state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    ADD   = 3'd3,
    EMIT  = 3'd4,
    GAP   = 3'd5,
    DONE  = 3'd6
  } fsm_t;

  // 0 - n in 5 bits equals 32 - n for every non-zero rotate amount
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (5'd0 - n));
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/chacha20_quarter_round.sv
// Combinational ChaCha20 quarter-round (add/xor/rotate by 16, 12, 8, 7).
module chacha20_quarter_round
  import chacha20_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  logic [31:0] a1_s, b1_s, c1_s, d1_s;

  // Quarter-round arithmetic, all adds wrap mod 2^32
  always_comb begin
    a1_s  = a + b;
    d1_s  = rotl32(d ^ a1_s, 5'd16);
    c1_s  = c + d1_s;
    b1_s  = rotl32(b ^ c1_s, 5'd12);
    a_new = a1_s + b1_s;
    d_new = rotl32(d1_s ^ a_new, 5'd8);
    c_new = c1_s + d_new;
    b_new = rotl32(b1_s ^ c_new, 5'd7);
  end

endmodule

// File: rtl/chacha20_led_top.sv
// ChaCha20 single-block LED demo: encrypts a ROM message and strobes it out bytewise.
// Define CHACHA20_SW_COUNTER_EN to take the block counter from SW instead of INIT_COUNTER.
module chacha20_led_top
  import chacha20_pkg::*;
#(
  parameter logic [255:0] KEY_VAL      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
  parameter logic [95:0]  NONCE_VAL    = 96'h000000000000004a00000000,
  parameter logic [31:0]  INIT_COUNTER = 32'd1,
  parameter int           MSG_LEN      = 26,
  parameter logic [511:0] MSG_VAL      = "Ladies and Gentlemen of th"
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  input  logic [9:0] SW,
  output logic [1:0] LEDG,
  output logic [7:0] LEDR
);

  // Message left-aligned so character 0 sits in the top byte
  localparam logic [511:0] MSG_ALIGN = MSG_VAL << (8 * (64 - MSG_LEN));
  localparam logic [5:0]   LAST_IDX  = 6'(MSG_LEN - 1);
  localparam logic [4:0]   LAST_RND  = 5'(ROUNDS - 1);

  logic        rst_s;
  fsm_t        state_r, state_nx_s;
  state_t      x_r, init_r, init_s, rnd_next_s, sum_s;
  logic [4:0]  rnd_r;
  logic [5:0]  idx_r, sel_s;
  logic [1:0]  ledg_r;
  logic [7:0]  ledr_r, out_byte_s;
  logic [31:0] counter_s, ks_word_s;
  logic        col_s;
  logic [3:0][31:0] qa_s, qb_s, qc_s, qd_s, na_s, nb_s, nc_s, nd_s;

  assign rst_s = KEY[0];
  assign col_s = ~rnd_r[0];
  assign LEDG  = ledg_r;
  assign LEDR  = ledr_r;

`ifdef CHACHA20_SW_COUNTER_EN
  assign counter_s = {22'd0, SW};
`else
  logic unused_sw_s;
  assign counter_s   = INIT_COUNTER;
  assign unused_sw_s = ^SW;
`endif

  // Initial block state from constants, key, counter and nonce
  always_comb begin
    init_s    = '0;
    init_s[0] = SIGMA0;
    init_s[1] = SIGMA1;
    init_s[2] = SIGMA2;
    init_s[3] = SIGMA3;
    for (int k = 0; k < 8; k++) begin
      init_s[4 + k] = bswap32(KEY_VAL[255 - 32 * k -: 32]);
    end
    init_s[12] = counter_s;
    for (int n = 0; n < 3; n++) begin
      init_s[13 + n] = bswap32(NONCE_VAL[95 - 32 * n -: 32]);
    end
  end

  // Route state words to the quarter-rounds: columns on even rounds, diagonals on odd
  always_comb begin
    qa_s = '0;
    qb_s = '0;
    qc_s = '0;
    qd_s = '0;
    for (int j = 0; j < 4; j++) begin
      qa_s[j] = x_r[j];
      if (col_s) begin
        qb_s[j] = x_r[4 + j];
        qc_s[j] = x_r[8 + j];
        qd_s[j] = x_r[12 + j];
      end else begin
        qb_s[j] = x_r[4 + ((j + 1) % 4)];
        qc_s[j] = x_r[8 + ((j + 2) % 4)];
        qd_s[j] = x_r[12 + ((j + 3) % 4)];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha20_quarter_round u_qr (
      .a(qa_s[g]), .b(qb_s[g]), .c(qc_s[g]), .d(qd_s[g]),
      .a_new(na_s[g]), .b_new(nb_s[g]), .c_new(nc_s[g]), .d_new(nd_s[g])
    );
  end

  // Write quarter-round results back to the words they were taken from
  always_comb begin
    rnd_next_s = x_r;
    for (int j = 0; j < 4; j++) begin
      rnd_next_s[j] = na_s[j];
      if (col_s) begin
        rnd_next_s[4 + j]  = nb_s[j];
        rnd_next_s[8 + j]  = nc_s[j];
        rnd_next_s[12 + j] = nd_s[j];
      end else begin
        rnd_next_s[4 + ((j + 1) % 4)]  = nb_s[j];
        rnd_next_s[8 + ((j + 2) % 4)]  = nc_s[j];
        rnd_next_s[12 + ((j + 3) % 4)] = nd_s[j];
      end
    end
  end

  // Feed-forward sum and ciphertext byte; in ADD the keystream is taken before it is registered
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum_s[i] = x_r[i] + init_r[i];
    end
    sel_s      = (state_r == GAP) ? idx_r + 6'd1 : idx_r;
    ks_word_s  = (state_r == ADD) ? sum_s[sel_s[5:2]] : x_r[sel_s[5:2]];
    out_byte_s = MSG_ALIGN[{~sel_s, 3'b000} +: 8] ^ ks_word_s[{sel_s[1:0], 3'b000} +: 8];
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or posedge rst_s) begin
    if (rst_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = INIT;
      INIT:    state_nx_s = ROUND;
      ROUND:   state_nx_s = (rnd_r == LAST_RND) ? ADD : ROUND;
      ADD:     state_nx_s = EMIT;
      EMIT:    state_nx_s = GAP;
      GAP:     state_nx_s = (idx_r == LAST_IDX) ? DONE : EMIT;
      DONE:    state_nx_s = DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and output registers; LEDG/LEDR are loaded on entry to each state
  always_ff @(posedge CLOCK_50 or posedge rst_s) begin
    if (rst_s) begin
      x_r    <= '0;
      init_r <= '0;
      rnd_r  <= 5'd0;
      idx_r  <= 6'd0;
      ledg_r <= 2'b00;
      ledr_r <= 8'h00;
    end else begin
      case (state_r)
        INIT: begin
          x_r    <= init_s;
          init_r <= init_s;
          rnd_r  <= 5'd0;
        end
        ROUND: begin
          x_r   <= rnd_next_s;
          rnd_r <= rnd_r + 5'd1;
        end
        ADD: begin
          x_r    <= sum_s;
          ledr_r <= out_byte_s;
          ledg_r <= 2'b01;
        end
        EMIT: ledg_r <= 2'b00;
        GAP: begin
          if (idx_r == LAST_IDX) begin
            ledg_r <= 2'b11;
          end else begin
            idx_r  <= idx_r + 6'd1;
            ledr_r <= out_byte_s;
            ledg_r <= 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_led_top.sv
// Scoreboard bench for chacha20_led_top: RFC 8439 vectors, strobe protocol, async reset restart.
module tb_chacha20_led_top;

  logic       clk = 1'b0;
  logic [0:0] key_m, key_a;
  logic [9:0] sw;
  logic [1:0] ledg_m, ledg_k, ledg_1, ledg_2;
  logic [7:0] ledr_m, ledr_k, ledr_1, ledr_2;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_m[$];
  logic [7:0] exp_k[$];
  logic [7:0] exp_1[$];
  logic [7:0] exp_2[$];
  logic [1:0] prev_m = 2'b00, prev_k = 2'b00, prev_1 = 2'b00, prev_2 = 2'b00;
  int strobes_m = 0, done_m = 0, strobes_k = 0, strobes_1 = 0, strobes_2 = 0;
  time t_rel, t_first_m, t_strobe_1, t_done_1;
  logic [7:0] byte_1, byte_2;

  // RFC 8439 sunscreen ciphertext, first 26 bytes (key 00..1f, nonce ..4a.., counter 1)
  localparam logic [7:0] CT [0:25] = '{
    8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80, 8'h41, 8'hba, 8'h07, 8'h28, 8'hdd,
    8'h0d, 8'h69, 8'h81, 8'he9, 8'h7e, 8'h7a, 8'hec, 8'h1d, 8'h43, 8'h60, 8'hc2, 8'h0a, 8'h27};
  // RFC 8439 block-function keystream (nonce 000000090000004a00000000, counter 1)
  localparam logic [7:0] KS [0:15] = '{
    8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
    8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};

  always #5 clk = ~clk;

  chacha20_led_top u_dut (
    .CLOCK_50(clk), .KEY(key_m), .SW(sw), .LEDG(ledg_m), .LEDR(ledr_m));

  chacha20_led_top #(.NONCE_VAL(96'h000000090000004a00000000), .MSG_LEN(16), .MSG_VAL(512'd0)) u_ks (
    .CLOCK_50(clk), .KEY(key_a), .SW(sw), .LEDG(ledg_k), .LEDR(ledr_k));

  chacha20_led_top #(.MSG_LEN(1), .MSG_VAL("L")) u_one (
    .CLOCK_50(clk), .KEY(key_a), .SW(sw), .LEDG(ledg_1), .LEDR(ledr_1));

  chacha20_led_top #(.INIT_COUNTER(32'd2), .MSG_LEN(1), .MSG_VAL("L")) u_c2 (
    .CLOCK_50(clk), .KEY(key_a), .SW(sw), .LEDG(ledg_2), .LEDR(ledr_2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising LEDG[0], pop the expected byte or count the done edge
  always @(negedge clk) begin
    if (ledg_m[0] && !prev_m[0]) begin
      if (ledg_m[1]) begin
        done_m++;
      end else begin
        strobes_m++;
        if (strobes_m == 1) t_first_m = $time;
        if (exp_m.size() == 0) check("dut_extra_strobe", 32'(strobes_m), 32'd0);
        else check("dut_byte", {24'd0, ledr_m}, {24'd0, exp_m.pop_front()});
      end
    end
    prev_m = ledg_m;

    if (ledg_k[0] && !prev_k[0] && !ledg_k[1]) begin
      strobes_k++;
      if (exp_k.size() == 0) check("ks_extra_strobe", 32'(strobes_k), 32'd0);
      else check("ks_byte", {24'd0, ledr_k}, {24'd0, exp_k.pop_front()});
    end
    prev_k = ledg_k;

    if (ledg_1[0] && !prev_1[0]) begin
      if (ledg_1[1]) begin
        t_done_1 = $time;
      end else begin
        strobes_1++;
        t_strobe_1 = $time;
        byte_1 = ledr_1;
        if (exp_1.size() == 0) check("len1_extra_strobe", 32'(strobes_1), 32'd0);
        else check("len1_byte", {24'd0, ledr_1}, {24'd0, exp_1.pop_front()});
      end
    end
    prev_1 = ledg_1;

    if (ledg_2[0] && !prev_2[0] && !ledg_2[1]) begin
      strobes_2++;
      byte_2 = ledr_2;
      if (exp_2.size() == 0) check("ctr2_extra_strobe", 32'(strobes_2), 32'd0);
      else check("ctr2_byte", {24'd0, ledr_2}, {24'd0, exp_2.pop_front()});
    end
    prev_2 = ledg_2;
  end

  initial begin
    key_m = 1'b1;
    key_a = 1'b1;
    sw    = 10'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_ledg", {30'd0, ledg_m}, 32'd0);
    check("reset_ledr", {24'd0, ledr_m}, 32'd0);

    for (int i = 0; i < 26; i++) exp_m.push_back(CT[i]);
    for (int i = 0; i < 16; i++) exp_k.push_back(KS[i]);
    exp_1.push_back(8'h6e);
    exp_2.push_back(8'h25);  // 'L' ^ 0x69, first keystream byte of block 2

    @(negedge clk);
    key_m = 1'b0;
    key_a = 1'b0;
    t_rel = $time;

    for (int i = 0; i < 200 && strobes_m < 11; i++) begin
      @(negedge clk);
      #1;
    end
    check("reach_byte10", 32'(strobes_m), 32'd11);
    check("first_latency", 32'((t_first_m - t_rel) / 10), 32'd23);
    check("byte10_strobe", {30'd0, ledg_m}, 32'd1);

    key_m = 1'b1;
    #1;
    check("async_ledg", {30'd0, ledg_m}, 32'd0);
    check("async_ledr", {24'd0, ledr_m}, 32'd0);

    exp_m.delete();
    strobes_m = 0;
    done_m = 0;
    t_first_m = 0;
    for (int i = 0; i < 26; i++) exp_m.push_back(CT[i]);
    repeat (2) @(negedge clk);
    key_m = 1'b0;
    t_rel = $time;

    for (int i = 0; i < 300 && done_m < 1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #1;
    check("restart_latency", 32'((t_first_m - t_rel) / 10), 32'd23);
    check("strobe_count", 32'(strobes_m), 32'd26);
    check("done_edges", 32'(done_m), 32'd1);
    check("dut_queue_left", 32'(exp_m.size()), 32'd0);
    check("done_ledg", {30'd0, ledg_m}, 32'd3);
    check("done_ledr", {24'd0, ledr_m}, 32'h27);

    check("ks_strobes", 32'(strobes_k), 32'd16);
    check("ks_queue_left", 32'(exp_k.size()), 32'd0);
    check("len1_strobes", 32'(strobes_1), 32'd1);
    check("len1_done_delay", 32'((t_done_1 - t_strobe_1) / 10), 32'd2);
    check("len1_done_ledg", {30'd0, ledg_1}, 32'd3);
    check("ctr2_queue_left", 32'(exp_2.size()), 32'd0);
    check("ctr2_differs", {31'd0, byte_2 == byte_1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
